// File: rtl/coffee_pkg.sv
// Shared encodings for the coffee vending controller: FSM states, button
// indices, the prioritised command decode and the credit width.
package coffee_pkg;

  localparam int CREDIT_W   = 10;
  localparam int BTN_COIN   = 0;
  localparam int BTN_BREW   = 1;
  localparam int BTN_RETURN = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_BREW   = 2'd2,
    ST_READY  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_COIN,
    CMD_BREW,
    CMD_RETURN
  } cmd_t;

  // Return beats brew beats coin; the losing pulses of that cycle are dropped.
  function automatic cmd_t decode_cmd(input logic [2:0] btn);
    if (btn[BTN_RETURN])    return CMD_RETURN;
    else if (btn[BTN_BREW]) return CMD_BREW;
    else if (btn[BTN_COIN]) return CMD_COIN;
    else                    return CMD_NONE;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick: counts 0..CLK_FREQ-1 and pulses on the last count.
// clear restarts the count so the next tick lands exactly CLK_FREQ cycles later.
module sec_tick_gen #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear || count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/coffee_ctrl_fsm.sv
// Coffee vending controller: credit bookkeeping, brew/ready timing in seconds,
// and change return, driven by debounced one-cycle button pulses.
module coffee_ctrl_fsm
  import coffee_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int COIN_VALUE   = 100,
  parameter int COFFEE_PRICE = 300,
  parameter int MAX_CREDIT   = 900,
  parameter int BREW_SEC     = 5,
  parameter int READY_SEC    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          btn_pulse,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state,
  output logic [3:0]          brew_remain,
  output logic                brewing,
  output logic                coffee_ready,
  output logic [CREDIT_W-1:0] change_out,
  output logic                change_valid
);

  // Credit sums are formed one bit wider so the ceiling compare cannot wrap.
  localparam logic [CREDIT_W:0]   COIN_X  = (CREDIT_W+1)'(COIN_VALUE);
  localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] COIN_V  = CREDIT_W'(COIN_VALUE);
  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(COFFEE_PRICE);
  localparam logic [3:0]          BREW_V  = 4'(BREW_SEC);
  localparam logic [3:0]          READY_V = 4'(READY_SEC);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [3:0]          remain_reg, remain_next;
  logic [CREDIT_W-1:0] change_reg, change_next;
  logic                valid_reg, valid_next;
  logic                tick_clear;
  logic                tick;
  logic [CREDIT_W:0]   coin_sum;
  cmd_t                cmd;

  sec_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      credit_reg <= '0;
      remain_reg <= '0;
      change_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      remain_reg <= remain_next;
      change_reg <= change_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    remain_next = remain_reg;
    change_next = change_reg;
    valid_next  = 1'b0;
    tick_clear  = 1'b0;
    cmd         = decode_cmd(btn_pulse);
    coin_sum    = {1'b0, credit_reg} + COIN_X;

    case (state_reg)
      ST_IDLE: begin
        if (cmd == CMD_COIN) begin
          credit_next = COIN_V;
          state_next  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (cmd == CMD_RETURN) begin
          change_next = credit_reg;
          valid_next  = 1'b1;
          credit_next = '0;
          state_next  = ST_IDLE;
        end else if (cmd == CMD_BREW) begin
          if (credit_reg >= PRICE_V) begin
            credit_next = credit_reg - PRICE_V;
            remain_next = BREW_V;
            tick_clear  = 1'b1;
            state_next  = ST_BREW;
          end
        end else if (cmd == CMD_COIN) begin
          if (coin_sum <= MAX_X) begin
            credit_next = coin_sum[CREDIT_W-1:0];
          end
        end
      end
      ST_BREW: begin
        if (tick) begin
          if (remain_reg == 4'd1) begin
            remain_next = READY_V;
            tick_clear  = 1'b1;
            state_next  = ST_READY;
          end else begin
            remain_next = remain_reg - 4'd1;
          end
        end
      end
      ST_READY: begin
        if (tick) begin
          remain_next = remain_reg - 4'd1;
          if (remain_reg == 4'd1) begin
            state_next = (credit_reg != '0) ? ST_CREDIT : ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign credit       = credit_reg;
  assign state        = state_reg;
  assign brew_remain  = remain_reg;
  assign brewing      = (state_reg == ST_BREW);
  assign coffee_ready = (state_reg == ST_READY);
  assign change_out   = change_reg;
  assign change_valid = valid_reg;

endmodule

// File: tb/tb_coffee_ctrl_fsm.sv
// Self-checking bench for coffee_ctrl_fsm: directed scenarios plus random button
// traffic, compared every cycle against a time-budget model of the machine.
module tb_coffee_ctrl_fsm;

  localparam int CF    = 10;
  localparam int COIN  = 100;
  localparam int PRICE = 300;
  localparam int MAXC  = 900;
  localparam int BSEC  = 5;
  localparam int RSEC  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] btn_pulse = 3'b000;
  logic [9:0] credit;
  logic [1:0] state;
  logic [3:0] brew_remain;
  logic       brewing;
  logic       coffee_ready;
  logic [9:0] change_out;
  logic       change_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0..3, credit, and cycles remaining in the timed phase.
  int m_phase  = 0;
  int m_credit = 0;
  int m_left   = 0;
  int m_change = 0;
  int m_valid  = 0;

  coffee_ctrl_fsm #(
    .CLK_FREQ(CF), .COIN_VALUE(COIN), .COFFEE_PRICE(PRICE),
    .MAX_CREDIT(MAXC), .BREW_SEC(BSEC), .READY_SEC(RSEC)
  ) dut (
    .clk(clk), .reset(reset), .btn_pulse(btn_pulse), .credit(credit),
    .state(state), .brew_remain(brew_remain), .brewing(brewing),
    .coffee_ready(coffee_ready), .change_out(change_out),
    .change_valid(change_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_remain();
    if (m_phase == 2 || m_phase == 3) return (m_left + CF - 1) / CF;
    return 0;
  endfunction

  task automatic model_edge(input logic [2:0] b);
    m_valid = 0;
    case (m_phase)
      0: if (!b[2] && !b[1] && b[0]) begin
           m_credit = COIN;
           m_phase  = 1;
         end
      1: begin
        if (b[2]) begin
          m_change = m_credit;
          m_valid  = 1;
          m_credit = 0;
          m_phase  = 0;
        end else if (b[1]) begin
          if (m_credit >= PRICE) begin
            m_credit -= PRICE;
            m_phase  = 2;
            m_left   = BSEC * CF;
          end
        end else if (b[0]) begin
          if (m_credit + COIN <= MAXC) m_credit += COIN;
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 3;
          m_left  = RSEC * CF;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = (m_credit > 0) ? 1 : 0;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},  int'(state), m_phase);
    check({tag, ".credit"}, int'(credit), m_credit);
    check({tag, ".remain"}, int'(brew_remain), model_remain());
    check({tag, ".brewing"}, int'(brewing), int'(m_phase == 2));
    check({tag, ".ready"},  int'(coffee_ready), int'(m_phase == 3));
    check({tag, ".cvalid"}, int'(change_valid), m_valid);
    check({tag, ".change"}, int'(change_out), m_change);
  endtask

  task automatic step(input logic [2:0] b, input string tag);
    @(negedge clk);
    btn_pulse = b;
    @(posedge clk);
    model_edge(b);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(3'b000, tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    btn_pulse = 3'b000;
    reset = 1'b1;
    #1;
    m_phase = 0; m_credit = 0; m_left = 0; m_change = 0; m_valid = 0;
    check_all("rst_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("rst_release");
  endtask

  initial begin
    do_reset();

    // Reset during a brew clears everything without a change pulse.
    for (int i = 0; i < 3; i++) step(3'b001, "pre_coin");
    step(3'b010, "pre_brew");
    idle(17, "pre_brewing");
    do_reset();
    idle(2, "post_rst");

    // Full brew cycle from exact price.
    step(3'b001, "c1"); check("c1.credit_const", int'(credit), 100);
    step(3'b001, "c2"); check("c2.credit_const", int'(credit), 200);
    step(3'b001, "c3"); check("c3.credit_const", int'(credit), 300);
    step(3'b010, "brew");
    check("brew.state_const", int'(state), 2);
    check("brew.remain_const", int'(brew_remain), BSEC);
    idle(BSEC * CF, "brewing");
    check("ready.state_const", int'(state), 3);
    check("ready.remain_const", int'(brew_remain), RSEC);
    idle(RSEC * CF, "ready");
    check("done.state_const", int'(state), 0);

    // Leftover credit returns to CREDIT, then change is returned.
    for (int i = 0; i < 5; i++) step(3'b001, "c5");
    step(3'b010, "brew500");
    idle((BSEC + RSEC) * CF, "brew500_run");
    check("left200.state_const", int'(state), 1);
    check("left200.credit_const", int'(credit), 200);
    step(3'b100, "ret200");
    check("ret200.change_const", int'(change_out), 200);
    step(3'b000, "ret200_after");

    // Insufficient credit brew and pulses during BREW are ignored.
    step(3'b001, "ins1"); step(3'b001, "ins2");
    step(3'b010, "ins_brew");
    step(3'b001, "ins3");
    step(3'b010, "ins_brew2");
    step(3'b001, "b_coin"); step(3'b010, "b_brew"); step(3'b100, "b_ret");
    step(3'b111, "b_all");
    idle((BSEC + RSEC) * CF, "ins_run");
    step(3'b100, "ins_ret");

    // Saturation at the ceiling.
    for (int i = 0; i < 10; i++) step(3'b001, "sat");
    check("sat.credit_const", int'(credit), MAXC);
    step(3'b100, "sat_ret");

    // Same-cycle priority.
    for (int i = 0; i < 4; i++) step(3'b001, "p400");
    step(3'b101, "pri_ret");
    check("pri_ret.change_const", int'(change_out), 400);
    for (int i = 0; i < 3; i++) step(3'b001, "p300");
    step(3'b011, "pri_brew");
    check("pri_brew.credit_const", int'(credit), 0);
    idle((BSEC + RSEC) * CF, "pri_run");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [2:0] b;
      r = $urandom_range(0, 9);
      case (r)
        5, 6:    b = 3'b001;
        7:       b = 3'b010;
        8:       b = 3'b100;
        9:       b = 3'($urandom_range(0, 7));
        default: b = 3'b000;
      endcase
      if ($urandom_range(0, 999) == 0) do_reset();
      else step(b, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
